// File: rtl/rtc_defs_pkg.sv
// Shared job indices, state encoding and arbitration helper for the RTC
// scheduler and the bus mux that follows bus_sel.
package rtc_defs;

  localparam logic [1:0] JOB_INIT  = 2'd0;
  localparam logic [1:0] JOB_WR    = 2'd1;
  localparam logic [1:0] JOB_HORA  = 2'd2;
  localparam logic [1:0] JOB_FECHA = 2'd3;
  localparam int         NJOBS     = 4;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_LAUNCH_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC   = 2'd2;
  localparam logic [1:0] ST_GAP_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_LAUNCH = ST_LAUNCH_ENC,
    ST_WAIT   = ST_WAIT_ENC,
    ST_GAP    = ST_GAP_ENC
  } state_e;

  // Fixed priority: lowest index wins.
  function automatic logic [1:0] pick_job(input logic [NJOBS-1:0] p);
    logic [1:0] k;
    k = JOB_FECHA;
    if (p[2]) k = JOB_HORA;
    if (p[1]) k = JOB_WR;
    if (p[0]) k = JOB_INIT;
    return k;
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Periodic read prescaler: tick_hora on every prescaler wrap, tick_fecha on
// every FECHA_DIV-th wrap.
module rtc_tick_gen #(
  parameter int TICK_CYCLES = 100000,
  parameter int FECHA_DIV   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic auto_en_i,
  output logic tick_hora_o,
  output logic tick_fecha_o
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (FECHA_DIV > 1) ? $clog2(FECHA_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          wrap, div_last;

  assign wrap     = auto_en_i && (cnt_q == PW'(TICK_CYCLES - 1));
  assign div_last = (div_q == DW'(FECHA_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (!auto_en_i || wrap) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
    // The divider only advances on wraps, so it keeps its phase across auto_en gaps.
    if (wrap) div_d = div_last ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign tick_hora_o  = wrap;
  assign tick_fecha_o = wrap && div_last;

endmodule

// File: rtl/rtc_access_scheduler.sv
// Arbitrates init / write / periodic-read jobs onto the single RTC bus:
// one job at a time, with a completion timeout and a recovery gap.
module rtc_access_scheduler
  import rtc_defs::*;
#(
  parameter int TICK_CYCLES    = 100000,
  parameter int FECHA_DIV      = 8,
  parameter int TIMEOUT_CYCLES = 63,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       wr_req,
  input  logic       auto_en,
  input  logic [3:0] done_vec,
  output logic [3:0] go,
  output logic [1:0] bus_sel,
  output logic       busy,
  output logic [3:0] pend,
  output logic       timeout_err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e        state_q, state_d;
  logic [1:0]    job_q, job_d;
  logic [3:0]    pend_q, pend_d, pend_clr;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          err_q, err_d;
  logic          tick_hora, tick_fecha;

  rtc_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .FECHA_DIV   (FECHA_DIV)
  ) u_tick (
    .clk          (clk),
    .reset        (reset),
    .auto_en_i    (auto_en),
    .tick_hora_o  (tick_hora),
    .tick_fecha_o (tick_fecha)
  );

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    err_d    = err_q;
    pend_clr = '0;
    case (state_q)
      ST_IDLE: if (|pend_q) begin
        job_d   = pick_job(pend_q);
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        pend_clr = 4'b0001 << job_q;
        wcnt_d   = '0;
        if (job_q == JOB_INIT) err_d = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_vec[job_q]) begin
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else if (wcnt_q == WW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                               gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // New requests win over the launch clear so a same-cycle repeat is not lost.
    pend_d = (pend_q & ~pend_clr) | {tick_fecha, tick_hora, wr_req, init_req};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
      pend_q  <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
    end
  end

  // Gated by reset so a reset landing on LAUNCH never emits a start pulse.
  assign go          = ((state_q == ST_LAUNCH) && reset) ? (4'b0001 << job_q) : 4'b0000;
  assign busy        = (state_q != ST_IDLE);
  assign bus_sel     = job_q;
  assign pend        = pend_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed bench for rtc_access_scheduler with short tick/timeout parameters.
module tb_rtc_access_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_req, wr_req, auto_en;
  logic [3:0] done_vec;
  logic [3:0] go;
  logic [1:0] bus_sel;
  logic       busy;
  logic [3:0] pend;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rtc_access_scheduler #(
    .TICK_CYCLES    (20),
    .FECHA_DIV      (2),
    .TIMEOUT_CYCLES (40),
    .GAP_CYCLES     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init_req    (init_req),
    .wr_req      (wr_req),
    .auto_en     (auto_en),
    .done_vec    (done_vec),
    .go          (go),
    .bus_sel     (bus_sel),
    .busy        (busy),
    .pend        (pend),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    int n_go, n_busy, s, done_at;
    logic [3:0] done_bits;
    int ev_off[$];
    logic [3:0] ev_go[$];
    int exp_off[7];
    logic [3:0] exp_go[7];

    exp_off = '{21, 41, 50, 61, 81, 90, 101};
    exp_go  = '{4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0100};

    reset = 1'b0; init_req = 1'b0; wr_req = 1'b0; auto_en = 1'b0; done_vec = 4'b0;
    repeat (3) step();
    chk("rst_go", go, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pend", pend, 4'b0);
    chk("rst_bus_sel", bus_sel, 2'd0);
    chk("rst_err", timeout_err, 1'b0);

    // Init job: request in cycle 10, go in 12, done in 30, idle in 33
    reset = 1'b1; cyc = 0;
    goto(10); init_req = 1'b1;
    step();   init_req = 1'b0;
    chk("init_pend_c11", pend, 4'b0001);
    chk("init_busy_c11", busy, 1'b0);
    step();
    chk("init_go_c12", go, 4'b0001);
    chk("init_busy_c12", busy, 1'b1);
    step();
    chk("init_go_c13", go, 4'b0);
    chk("init_pend_c13", pend, 4'b0);
    goto(30);
    chk("init_busy_c30", busy, 1'b1);
    done_vec = 4'b0001;
    step(); done_vec = 4'b0;
    goto(32);
    chk("init_busy_c32", busy, 1'b1);
    step();
    chk("init_busy_c33", busy, 1'b0);

    // Simultaneous init and write
    init_req = 1'b1; wr_req = 1'b1;
    step(); init_req = 1'b0; wr_req = 1'b0;
    chk("both_pend_c34", pend, 4'b0011);
    step();
    chk("both_go0_c35", go, 4'b0001);
    step();
    chk("both_pend_c36", pend, 4'b0010);
    done_vec = 4'b0001;
    step(); done_vec = 4'b0;
    goto(39);
    chk("both_go_gap_c39", go, 4'b0);
    chk("both_idle_c39", busy, 1'b0);
    chk("both_bus_hold_c39", bus_sel, 2'd0);
    step();
    chk("both_go1_c40", go, 4'b0010);
    chk("both_bus_sel_c40", bus_sel, 2'd1);

    // Foreign done bits ignored in WAIT, then timeout
    step();
    done_vec = 4'b0100;
    step(); done_vec = 4'b0001;
    step(); done_vec = 4'b0;
    chk("foreign_busy_c43", busy, 1'b1);
    goto(45); wr_req = 1'b1;
    step(); wr_req = 1'b0;
    goto(80);
    chk("to_err_c80", timeout_err, 1'b0);
    chk("to_busy_c80", busy, 1'b1);
    chk("to_bus_sel_c80", bus_sel, 2'd1);
    step();
    chk("to_err_c81", timeout_err, 1'b1);
    goto(83);
    chk("to_idle_c83", busy, 1'b0);
    chk("to_pend_c83", pend, 4'b0010);
    step();
    chk("to_next_go_c84", go, 4'b0010);
    chk("to_err_c84", timeout_err, 1'b1);
    step();
    done_vec = 4'b0010;
    step(); done_vec = 4'b0;
    goto(88);
    chk("to_idle_c88", busy, 1'b0);
    init_req = 1'b1;
    step(); init_req = 1'b0;
    step();
    chk("clr_go_c90", go, 4'b0001);
    chk("clr_err_c90", timeout_err, 1'b1);
    step();
    chk("clr_err_c91", timeout_err, 1'b0);

    // Reset during WAIT with a write pending
    step(); wr_req = 1'b1;
    step(); wr_req = 1'b0;
    chk("rw_pend_c93", pend, 4'b0010);
    reset = 1'b0;
    step();
    chk("rw_busy", busy, 1'b0);
    chk("rw_pend", pend, 4'b0);
    chk("rw_go", go, 4'b0);
    reset = 1'b1;
    n_go = 0; n_busy = 0;
    repeat (30) begin
      step();
      if (go != 4'b0) n_go++;
      if (busy) n_busy++;
    end
    chk("rw_no_restart_go", n_go, 0);
    chk("rw_no_restart_busy", n_busy, 0);

    // Reset landing on LAUNCH suppresses go in that cycle
    init_req = 1'b1;
    step(); init_req = 1'b0;
    step();
    chk("rl_go_pre", go, 4'b0001);
    reset = 1'b0;
    #1;
    chk("rl_go_masked", go, 4'b0);
    step();
    chk("rl_busy", busy, 1'b0);
    chk("rl_pend", pend, 4'b0);
    reset = 1'b1;

    // Periodic reads: 100 cycles of auto_en, responder returns done 5 cycles after go
    s = cyc; done_at = -1; done_bits = 4'b0;
    while (cyc < s + 130) begin
      if (go != 4'b0) begin
        ev_off.push_back(cyc - s);
        ev_go.push_back(go);
        done_at   = cyc + 5;
        done_bits = go;
      end
      done_vec = (cyc == done_at) ? done_bits : 4'b0;
      auto_en  = (cyc < s + 100);
      step();
    end
    done_vec = 4'b0; auto_en = 1'b0;
    chk("auto_num_go", ev_off.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("auto_off_%0d", i), (i < ev_off.size()) ? ev_off[i] : -1, exp_off[i]);
      chk($sformatf("auto_go_%0d", i), (i < ev_go.size()) ? {28'd0, ev_go[i]} : 32'hffff_ffff,
          {28'd0, exp_go[i]});
    end
    chk("auto_end_busy", busy, 1'b0);
    chk("auto_end_pend", pend, 4'b0);
    chk("auto_end_err", timeout_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_access_scheduler.md
RTC_ACCESS_SCHEDULER -- requirements
Module: rtc_access_scheduler

Interface
REQ-001 The block SHALL have the parameter TICK_CYCLES, default 100000: the number of clk cycles per periodic time-read tick.
REQ-002 The block SHALL have the parameter FECHA_DIV, default 8: the number of ticks per date read.
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 63: the maximum number of WAIT cycles before a job is aborted.
REQ-004 The block SHALL have the parameter GAP_CYCLES, default 2: the number of bus-idle recovery cycles after each job.
REQ-005 The block SHALL have the port clk  in  1  the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have the port reset  in  1  reset, synchronous and active-low (0 = reset).
REQ-007 The block SHALL have the port init_req  in  1  one-cycle request to initialise the RTC.
REQ-008 The block SHALL have the port wr_req  in  1  one-cycle request to write user-edited time/date to the RTC.
REQ-009 The block SHALL have the port auto_en  in  1  enable for the periodic reads.
REQ-010 The block SHALL have the port done_vec  in  4  one-hot completion pulses from the sub-FSMs: [0] init, [1] write, [2] read time, [3] read date.
REQ-011 The block SHALL have the port go  out  4  one-cycle start pulses, using the same index map as done_vec.
REQ-012 The block SHALL have the port bus_sel  out  2  index of the job that owns the RTC bus and RAM path.
REQ-013 The block SHALL have the port busy  out  1  high while a job is in progress.
REQ-014 The block SHALL have the port pend  out  4  pending-request flags.
REQ-015 The block SHALL have the port timeout_err  out  1  sticky error flag for an aborted job.

Function
REQ-016 The block SHALL implement a prescaler that counts 0..TICK_CYCLES-1 while auto_en=1, wraps to 0, and is held at 0 while auto_en=0.
REQ-017 On each prescaler wrap the block SHALL set pend[2]; on every FECHA_DIV-th wrap it SHALL also set pend[3].
REQ-018 An init_req pulse SHALL set pend[0], and a wr_req pulse SHALL set pend[1].
REQ-019 Pending flags SHALL be one deep: repeat requests coalesce, and a set in the same cycle as a clear wins.
REQ-020 The block SHALL implement the states IDLE, LAUNCH, WAIT and GAP.
REQ-021 In IDLE with pend≠0, the next state SHALL be LAUNCH, with job k chosen by fixed priority 0 > 1 > 2 > 3 and k registered.
REQ-022 In LAUNCH the block SHALL drive go[k]=1 for exactly one cycle, clear pend[k], and go to WAIT.
REQ-023 The go pulse SHALL occur 2 cycles after a request pulse when the block is IDLE.
REQ-024 In WAIT, done_vec[k]=1 SHALL move the block to GAP; done bits of other indices SHALL be ignored.
REQ-025 done_vec SHALL be ignored outside WAIT.
REQ-026 In WAIT, if TIMEOUT_CYCLES cycles elapse without done_vec[k], the block SHALL set timeout_err and move to GAP.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles and then return to IDLE; requests are re-arbitrated only in IDLE.
REQ-028 bus_sel SHALL equal k from LAUNCH through the end of GAP, and hold its last value in IDLE.
REQ-029 busy SHALL be 1 in LAUNCH, WAIT and GAP, and 0 in IDLE.
REQ-030 timeout_err SHALL clear only when an init job is launched (LAUNCH with k=0) or on reset.
REQ-031 At most one go bit SHALL be high in any cycle, and never two launches without an intervening GAP.
REQ-032 While auto_en=0, already-pending read flags SHALL still be serviced.

Reset
REQ-033 On reset=0 at a clock edge, the state SHALL become IDLE and go=0, pend=0, bus_sel=0, busy=0 and timeout_err=0.
REQ-034 On reset=0 at a clock edge, the prescaler, tick divider, WAIT counter and GAP counter SHALL all be set to 0.
REQ-035 A reset during a job SHALL abort it immediately, with no go pulse issued in the reset cycle.
REQ-036 After reset, no job SHALL restart unless a new request arrives; the sub-FSMs share the same reset.

Structure
REQ-037 The job indices (INIT=0, WR=1, HORA=2, FECHA=3) and state encodings SHALL be defined as localparam constants in a shared header file, rtc_defs, used by this block and by the bus mux.
REQ-038 The prescaler and tick divider SHALL be a sub-module, rtc_tick_gen, that outputs tick_hora and tick_fecha pulses.
REQ-039 The arbiter and state machine SHALL remain in the top level.

Verification
(All scenarios use TICK_CYCLES=20, FECHA_DIV=2, TIMEOUT_CYCLES=40, GAP_CYCLES=2.)
REQ-040 Reset release, then an init_req pulse in cycle 10 -> go=0001 in cycle 12 and busy=1 from cycle 12; done_vec[0] in cycle 30 -> busy=0 in cycle 33.
REQ-041 auto_en=1 for 100 cycles with the bench returning done 5 cycles after each go -> go[2] pulses on ticks 1-5 and go[3] on ticks 2 and 4, with fecha launched after hora.
REQ-042 init_req and wr_req in the same cycle while IDLE -> go[0] first and go[1] only after the init job's GAP; pend shows 0010 during the init job.
REQ-043 No done returned after go[1] -> timeout_err=1 after 40 WAIT cycles and the next pending job launches; a later init launch clears timeout_err.
REQ-044 reset=0 asserted in WAIT -> next cycle busy=0, pend=0, go=0, and no go pulse until a new request.
REQ-045 done_vec=0100 injected while job 1 is in WAIT -> ignored, and the block stays in WAIT until done_vec[1].
